// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline stages
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int SKID_DEPTH      = 2;
  localparam int OCC_W           = $clog2(SKID_DEPTH + 1);
  // Payload width shared with pipeline_flops so the two stages line up.
  localparam int PIPE_DATA_WIDTH = 16;

endpackage

// File: rtl/pipeline_skid_stage_if.sv
// rtl/pipeline_skid_stage_if.sv - valid/ready/data stream bundle
interface pipeline_skid_stage_if #(
  parameter int DATA_WIDTH = pipeline_pkg::PIPE_DATA_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enable flop with synchronous active-high clear
module en_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_skid_stage.sv
// rtl/pipeline_skid_stage.sv - two-entry elastic stage with registered handshake outputs
module pipeline_skid_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipeline_skid_stage_if.slave  s,
  pipeline_skid_stage_if.master m,
  output logic [OCC_W-1:0]      occupancy
);

  skid_state_e           state;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  accept;
  logic                  pop;
  logic                  main_en;
  logic                  skid_en;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

  assign accept = s.valid && s_ready_q;
  assign pop    = m_valid_q && m.ready;

  // A flush still lets the pop complete but must not load the word accepted alongside it.
  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = s.data;
    if (!flush) begin
      case (state)
        EMPTY: main_en = accept;
        BUSY: begin
          if (accept && pop) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: ;
      endcase
    end
  end

  en_reg #(.WIDTH(DATA_WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  en_reg #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (s.data),
    .q   (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      occ_q     <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            state     <= BUSY;
            m_valid_q <= 1'b1;
            occ_q     <= OCC_W'(1);
          end
        end
        BUSY: begin
          if (accept && !pop) begin
            state     <= FULL;
            s_ready_q <= 1'b0;
            occ_q     <= OCC_W'(2);
          end else if (pop && !accept) begin
            state     <= EMPTY;
            m_valid_q <= 1'b0;
            occ_q     <= '0;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= BUSY;
            s_ready_q <= 1'b1;
            occ_q     <= OCC_W'(1);
          end
        end
        default: begin
          state     <= EMPTY;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
          occ_q     <= '0;
        end
      endcase
    end
  end

  assign s.ready   = s_ready_q;
  assign m.valid   = m_valid_q;
  assign m.data    = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// tb/tb_pipeline_skid_stage.sv - directed bench with queue model for pipeline_skid_stage
module tb_pipeline_skid_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  pipeline_skid_stage_if #(.DATA_WIDTH(16)) sif ();
  pipeline_skid_stage_if #(.DATA_WIDTH(16)) mif ();

  pipeline_skid_stage #(.DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s         (sif),
    .m         (mif),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity two whose ready is "room after this edge".
  logic [15:0] mq[$];
  logic [15:0] pops[$];
  bit          m_sready = 1'b0;
  bit          m_rst    = 1'b0;
  bit          started  = 1'b0;
  bit          seen3333 = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit pp;
    acc     = sif.valid && m_sready;
    pp      = (mq.size() > 0) && mif.ready;
    m_rst   = rst;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_sready = 1'b0;
    end else begin
      if (pp) pops.push_back(mq.pop_front());
      if (flush) mq.delete();
      else if (acc) mq.push_back(sif.data);
      m_sready = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", {31'd0, sif.ready}, {31'd0, m_sready});
      chk("m_valid", {31'd0, mif.valid}, {31'd0, mq.size() > 0});
      chk("occupancy", {30'd0, occupancy}, mq.size());
      if (mq.size() > 0) chk("m_data", {16'd0, mif.data}, {16'd0, mq[0]});
      if (m_rst) chk("m_data_reset", {16'd0, mif.data}, 32'd0);
      if (mif.valid && mif.data == 16'h3333) seen3333 = 1'b1;
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic r,
                     input logic f, input logic rs);
    sif.valid = v;
    sif.data  = d;
    mif.ready = r;
    flush     = f;
    rst       = rs;
    @(negedge clk);
  endtask

  logic [15:0] exp_pops [12] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                 16'h0005, 16'h0006, 16'h0007, 16'h0008,
                                 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h5A5A};

  initial begin
    sif.valid = 1'b0;
    sif.data  = '0;
    mif.ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b1;

    // 1: reset and release
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_s_ready", {31'd0, sif.ready}, 32'd0);
      chk("rst_m_valid", {31'd0, mif.valid}, 32'd0);
      chk("rst_m_data", {16'd0, mif.data}, 32'd0);
      chk("rst_occ", {30'd0, occupancy}, 32'd0);
    end
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("release_s_ready", {31'd0, sif.ready}, 32'd1);

    // 2: full-throughput streaming
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_m_data", {16'd0, mif.data}, i);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
      chk("stream_s_ready", {31'd0, sif.ready}, 32'd1);
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_occ", {30'd0, occupancy}, 32'd0);

    // 3: stall fills both entries, third word refused
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    chk("fill1_occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    chk("fill2_occ", {30'd0, occupancy}, 32'd2);
    chk("fill2_s_ready", {31'd0, sif.ready}, 32'd0);
    chk("fill2_m_data", {16'd0, mif.data}, 32'h0000AAAA);
    cyc(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0);
    chk("refuse_occ", {30'd0, occupancy}, 32'd2);
    chk("refuse_m_data", {16'd0, mif.data}, 32'h0000AAAA);

    // 4: drain in order, then the refused word goes through
    cyc(1'b0, 16'hCCCC, 1'b1, 1'b0, 1'b0);
    chk("pop1_occ", {30'd0, occupancy}, 32'd1);
    chk("pop1_m_data", {16'd0, mif.data}, 32'h0000BBBB);
    chk("pop1_s_ready", {31'd0, sif.ready}, 32'd1);
    cyc(1'b0, 16'hCCCC, 1'b1, 1'b0, 1'b0);
    chk("pop2_occ", {30'd0, occupancy}, 32'd0);
    chk("pop2_m_valid", {31'd0, mif.valid}, 32'd0);
    cyc(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0);
    chk("ccc_m_data", {16'd0, mif.data}, 32'h0000CCCC);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // 5: flush while full with a concurrent offer
    cyc(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_occ", {30'd0, occupancy}, 32'd2);
    cyc(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
    chk("flush_m_valid", {31'd0, mif.valid}, 32'd0);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_s_ready", {31'd0, sif.ready}, 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // 6: reset mid-stream while full
    cyc(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    cyc(1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
    chk("midrst_m_valid", {31'd0, mif.valid}, 32'd0);
    chk("midrst_m_data", {16'd0, mif.data}, 32'd0);
    chk("midrst_s_ready", {31'd0, sif.ready}, 32'd0);
    chk("midrst_occ", {30'd0, occupancy}, 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    chk("post_rst_m_data", {16'd0, mif.data}, 32'h00005A5A);
    chk("post_rst_occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    chk("no_3333", {31'd0, seen3333}, 32'd0);
    chk("pop_count", pops.size(), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < pops.size()) chk("pop_order", {16'd0, pops[i]}, {16'd0, exp_pops[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
